maxpool_relu_stream: RTL and testbench

MAXPOOL_RELU_STREAM -- requirements
Module: maxpool_relu_stream

---
 rtl/cnn_pkg.sv | 15 +
 rtl/maxpool_relu_stream_if.sv | 24 ++
 rtl/pool_row_buffer.sv | 28 ++
 rtl/maxpool_relu_stream.sv | 130 +++++++++++++
 tb/tb_maxpool_relu_stream.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN sample types, widths and signed max helper
package cnn_pkg;

   localparam int CNN_DATA_BITS = 8;
   localparam int WIDE_BITS     = 32;

   typedef logic signed [CNN_DATA_BITS-1:0] sample_t;
   typedef logic signed [WIDE_BITS-1:0]     wide_t;

   // Callers sign-extend narrower lanes into wide_t so one helper serves any DATA_BITS.
   function automatic wide_t smax(input wide_t a, input wide_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/maxpool_relu_stream_if.sv
// rtl/maxpool_relu_stream_if.sv - pixel stream in / pooled stream out bundle
import cnn_pkg::*;

interface maxpool_relu_stream_if #(
   parameter int CHANNELS  = 4,
   parameter int DATA_BITS = CNN_DATA_BITS
);
   logic                          in_val;
   logic                          frame_clr;
   logic [CHANNELS*DATA_BITS-1:0] data_in;
   logic [CHANNELS*DATA_BITS-1:0] data_out;
   logic                          valid;
   logic                          last;

   modport master (
      output in_val, frame_clr, data_in,
      input  data_out, valid, last
   );

   modport slave (
      input  in_val, frame_clr, data_in,
      output data_out, valid, last
   );
endinterface

// File: rtl/pool_row_buffer.sv
// rtl/pool_row_buffer.sv - running-max storage, one entry per pooling window column
import cnn_pkg::*;

module pool_row_buffer #(
   parameter int DEPTH = 14,
   parameter int DW    = 32,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data
);

   logic [DW-1:0] mem [DEPTH];

   // Asynchronous read lets the top read-modify-write the same entry in one cycle.
   assign rd_data = mem[rd_addr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: rtl/maxpool_relu_stream.sv
// rtl/maxpool_relu_stream.sv - streaming non-overlapping POOLxPOOL max pool with optional ReLU
import cnn_pkg::*;

module maxpool_relu_stream #(
   parameter int WIDTH     = 28,
   parameter int HEIGHT    = 28,
   parameter int CHANNELS  = 4,
   parameter int POOL      = 2,
   parameter int DATA_BITS = CNN_DATA_BITS,
   parameter int RELU_EN   = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   maxpool_relu_stream_if.slave bus
);

   localparam int NWIN = WIDTH / POOL;
   localparam int IW   = (NWIN > 1) ? $clog2(NWIN) : 1;
   localparam int CW   = $clog2(WIDTH);
   localparam int RW   = $clog2(HEIGHT);
   localparam int PW   = $clog2(POOL);
   localparam int DW   = CHANNELS * DATA_BITS;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [PW-1:0] col_ph;
   logic [PW-1:0] row_ph;
   logic [IW-1:0] widx;

   logic          accept;
   logic          win_start;
   logic          win_done;
   logic          eol;
   logic          eof;

   logic [DW-1:0] entry;
   logic [DW-1:0] merged;
   logic [DW-1:0] pooled;
   logic [DATA_BITS-1:0] lane;
   wide_t         ea;
   wide_t         es;

   assign accept    = bus.in_val && !bus.frame_clr;
   assign win_start = (row_ph == '0) && (col_ph == '0);
   assign win_done  = (row_ph == PW'(POOL-1)) && (col_ph == PW'(POOL-1));
   assign eol       = (col == CW'(WIDTH-1));
   assign eof       = eol && (row == RW'(HEIGHT-1));

   // Phase counters and the window index stand in for col%POOL, row%POOL and col/POOL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col    <= '0;
         row    <= '0;
         col_ph <= '0;
         row_ph <= '0;
         widx   <= '0;
      end else if (bus.frame_clr) begin
         col    <= '0;
         row    <= '0;
         col_ph <= '0;
         row_ph <= '0;
         widx   <= '0;
      end else if (bus.in_val) begin
         if (eol) begin
            col    <= '0;
            col_ph <= '0;
            widx   <= '0;
            if (eof) begin
               row    <= '0;
               row_ph <= '0;
            end else begin
               row    <= row + 1'b1;
               row_ph <= (row_ph == PW'(POOL-1)) ? '0 : row_ph + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
            if (col_ph == PW'(POOL-1)) begin
               col_ph <= '0;
               widx   <= widx + 1'b1;
            end else begin
               col_ph <= col_ph + 1'b1;
            end
         end
      end
   end

   pool_row_buffer #(
      .DEPTH (NWIN),
      .DW    (DW),
      .AW    (IW)
   ) u_buf (
      .clk     (clk),
      .rd_addr (widx),
      .rd_data (entry),
      .wr_en   (accept),
      .wr_addr (widx),
      .wr_data (merged)
   );

   always_comb begin
      merged = '0;
      pooled = '0;
      lane   = '0;
      ea     = '0;
      es     = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         ea   = wide_t'($signed(entry[k*DATA_BITS +: DATA_BITS]));
         es   = wide_t'($signed(bus.data_in[k*DATA_BITS +: DATA_BITS]));
         lane = DATA_BITS'(win_start ? es : smax(ea, es));
         merged[k*DATA_BITS +: DATA_BITS] = lane;
         pooled[k*DATA_BITS +: DATA_BITS] =
            ((RELU_EN != 0) && lane[DATA_BITS-1]) ? {DATA_BITS{1'b0}} : lane;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.valid    <= 1'b0;
         bus.last     <= 1'b0;
         bus.data_out <= '0;
      end else begin
         bus.valid <= accept && win_done;
         bus.last  <= accept && win_done && eof;
         if (accept && win_done) begin
            bus.data_out <= pooled;
         end
      end
   end

endmodule

// File: tb/tb_maxpool_relu_stream.sv
// tb/tb_maxpool_relu_stream.sv - directed vector bench for maxpool_relu_stream
import cnn_pkg::*;

module tb_maxpool_relu_stream;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   maxpool_relu_stream_if #(.CHANNELS(1), .DATA_BITS(8)) a_if ();
   maxpool_relu_stream_if #(.CHANNELS(1), .DATA_BITS(8)) b_if ();
   maxpool_relu_stream_if #(.CHANNELS(4), .DATA_BITS(8)) c_if ();

   maxpool_relu_stream #(.WIDTH(4), .HEIGHT(4), .CHANNELS(1), .POOL(2), .DATA_BITS(8), .RELU_EN(1))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
   maxpool_relu_stream #(.WIDTH(4), .HEIGHT(4), .CHANNELS(1), .POOL(2), .DATA_BITS(8), .RELU_EN(0))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
   maxpool_relu_stream #(.WIDTH(28), .HEIGHT(28), .CHANNELS(4), .POOL(2), .DATA_BITS(8), .RELU_EN(1))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

   typedef struct packed {
      logic [7:0] din;
      logic       ev;
      logic [7:0] ea;
      logic [7:0] eb;
      logic       el;
   } vec_t;

   vec_t tab [48];

   logic [7:0] frames [3][16] = '{
      '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
        8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15},
      '{16{8'hFD}},
      '{8'hFB, 8'hFE, 8'h07, 8'h01, 8'hF8, 8'hFF, 8'h03, 8'h09,
        8'h04, 8'hFA, 8'hF9, 8'hF7, 8'h00, 8'h02, 8'hFD, 8'hFC}
   };
   logic [7:0] outs_a [3][4] = '{'{8'd5, 8'd7, 8'd13, 8'd15}, '{4{8'h00}}, '{8'h00, 8'h09, 8'h04, 8'h00}};
   logic [7:0] outs_b [3][4] = '{'{8'd5, 8'd7, 8'd13, 8'd15}, '{4{8'hFD}}, '{8'hFF, 8'h09, 8'h04, 8'hFD}};

   int nvec = 0;
   int nerr = 0;

   logic [31:0] cq [$];
   logic        cl [$];

   always @(posedge clk) begin
      #1;
      if (c_if.valid) begin
         cq.push_back(c_if.data_out);
         cl.push_back(c_if.last);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pix(input int salt, input int r, input int c);
      logic [31:0] v;
      int p;
      v = '0;
      p = r * 28 + c + salt;
      for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(p * (k + 1));
      return v;
   endfunction

   function automatic logic [31:0] exp_win(input int salt, input int wr, input int wc);
      logic [31:0] v;
      logic [31:0] t;
      int m;
      int s;
      v = '0;
      for (int k = 0; k < 4; k++) begin
         m = -1000;
         for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
               t = pix(salt, 2 * wr + dr, 2 * wc + dc);
               s = int'($signed(t[k*8 +: 8]));
               if (s > m) m = s;
            end
         end
         if (m < 0) m = 0;
         v[k*8 +: 8] = 8'(m);
      end
      return v;
   endfunction

   task automatic idle(input int n);
      a_if.in_val = 1'b0;
      b_if.in_val = 1'b0;
      c_if.in_val = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_c(input int salt, input bit gaps, input int npix);
      for (int p = 0; p < npix; p++) begin
         while (gaps && $urandom_range(0, 1) == 1) begin
            c_if.in_val  = 1'b0;
            c_if.data_in = $urandom;
            @(posedge clk);
            #1;
         end
         c_if.in_val  = 1'b1;
         c_if.data_in = pix(salt, p / 28, p % 28);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_c(input int s0, input int s1, input int nf);
      int lim;
      int w;
      chk("c_valid_count", cq.size(), nf * 196);
      lim = (cq.size() < nf * 196) ? cq.size() : nf * 196;
      for (int i = 0; i < lim; i++) begin
         w = i % 196;
         chk("c_data", cq[i], exp_win((i >= 196) ? s1 : s0, w / 14, w % 14));
         chk("c_last", {31'd0, cl[i]}, {31'd0, (w == 195)});
      end
   endtask

   logic [7:0] held_a;
   logic [7:0] held_b;
   int         slot;

   initial begin
      rst_n = 1'b0;
      a_if.in_val = 1'b0; a_if.frame_clr = 1'b0; a_if.data_in = '0;
      b_if.in_val = 1'b0; b_if.frame_clr = 1'b0; b_if.data_in = '0;
      c_if.in_val = 1'b0; c_if.frame_clr = 1'b0; c_if.data_in = '0;

      for (int i = 0; i < 48; i++) begin
         slot = ((i % 16) == 5) ? 0 : ((i % 16) == 7) ? 1 : ((i % 16) == 13) ? 2 : ((i % 16) == 15) ? 3 : -1;
         tab[i].din = frames[i / 16][i % 16];
         tab[i].ev  = (slot >= 0);
         tab[i].ea  = (slot >= 0) ? outs_a[i / 16][slot] : 8'h00;
         tab[i].eb  = (slot >= 0) ? outs_b[i / 16][slot] : 8'h00;
         tab[i].el  = (slot == 3);
      end

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);
      chk("rst_a_valid", {31'd0, a_if.valid}, 32'd0);
      chk("rst_a_last",  {31'd0, a_if.last},  32'd0);
      chk("rst_a_data",  {24'd0, a_if.data_out}, 32'd0);
      chk("rst_b_data",  {24'd0, b_if.data_out}, 32'd0);
      chk("rst_c_valid", {31'd0, c_if.valid}, 32'd0);
      chk("rst_c_data",  c_if.data_out, 32'd0);

      held_a = 8'h00;
      held_b = 8'h00;
      for (int i = 0; i < 48; i++) begin
         a_if.in_val  = 1'b1; a_if.data_in = tab[i].din;
         b_if.in_val  = 1'b1; b_if.data_in = tab[i].din;
         @(posedge clk);
         #1;
         if (tab[i].ev) begin
            held_a = tab[i].ea;
            held_b = tab[i].eb;
         end
         chk("a_valid", {31'd0, a_if.valid}, {31'd0, tab[i].ev});
         chk("b_valid", {31'd0, b_if.valid}, {31'd0, tab[i].ev});
         chk("a_last",  {31'd0, a_if.last},  {31'd0, tab[i].el});
         chk("b_last",  {31'd0, b_if.last},  {31'd0, tab[i].el});
         chk("a_data",  {24'd0, a_if.data_out}, {24'd0, held_a});
         chk("b_data",  {24'd0, b_if.data_out}, {24'd0, held_b});
      end
      idle(2);
      chk("a_idle_valid", {31'd0, a_if.valid}, 32'd0);
      chk("a_idle_hold",  {24'd0, a_if.data_out}, {24'd0, held_a});

      // Two frames back to back, no gap cycle between them.
      drive_c(11, 1'b0, 784);
      drive_c(23, 1'b0, 784);
      idle(3);
      check_c(11, 23, 2);
      cq.delete(); cl.delete();

      drive_c(11, 1'b1, 784);
      idle(3);
      check_c(11, 11, 1);
      cq.delete(); cl.delete();

      // Abort via frame_clr in row 3, on a pixel that would have closed a window.
      drive_c(50, 1'b0, 95);
      c_if.in_val    = 1'b1;
      c_if.frame_clr = 1'b1;
      c_if.data_in   = pix(50, 3, 11);
      @(posedge clk);
      #1;
      c_if.frame_clr = 1'b0;
      chk("clr_no_valid", {31'd0, c_if.valid}, 32'd0);
      idle(2);
      chk("clr_partial_count", cq.size(), 32'd19);
      cq.delete(); cl.delete();
      drive_c(61, 1'b0, 784);
      idle(3);
      check_c(61, 61, 1);
      cq.delete(); cl.delete();

      // Asynchronous reset in row 3 of a partial frame.
      drive_c(70, 1'b0, 95);
      c_if.in_val  = 1'b1;
      c_if.data_in = pix(70, 3, 11);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, c_if.valid}, 32'd0);
      chk("arst_last",  {31'd0, c_if.last},  32'd0);
      chk("arst_data",  c_if.data_out, 32'd0);
      @(posedge clk);
      #1;
      chk("arst_hold_valid", {31'd0, c_if.valid}, 32'd0);
      rst_n = 1'b1;
      idle(1);
      cq.delete(); cl.delete();
      drive_c(83, 1'b0, 784);
      idle(3);
      check_c(83, 83, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
